seg7_scan_driver: RTL

//  Transmit side of the board's multiplexed 7-segment interface (seg_data/seg_com).

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment bit positions, scan FSM encoding and hex decode table
package seg7_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } scan_state_t;

   // Active-high {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] segs;
      case (nibble)
         4'h0: segs = 7'h3F;
         4'h1: segs = 7'h06;
         4'h2: segs = 7'h5B;
         4'h3: segs = 7'h4F;
         4'h4: segs = 7'h66;
         4'h5: segs = 7'h6D;
         4'h6: segs = 7'h7D;
         4'h7: segs = 7'h07;
         4'h8: segs = 7'h7F;
         4'h9: segs = 7'h6F;
         4'hA: segs = 7'h77;
         4'hB: segs = 7'h7C;
         4'hC: segs = 7'h39;
         4'hD: segs = 7'h5E;
         4'hE: segs = 7'h79;
         default: segs = 7'h71;
      endcase
      return segs;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-high abcdefg pattern
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered multiplexed 7-segment scanner with blank gap
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 6,
   parameter int DIGIT_CYCLES = 20833,
   parameter int BLANK_CYCLES = 125,
   parameter bit SEG_ACT_LOW  = 1'b0,
   parameter bit COM_ACT_LOW  = 1'b1
) (
   input  logic                    clk_125mhz,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   load_data,
   input  logic [N_DIGITS-1:0]     dp_mask,
   input  logic [N_DIGITS-1:0]     blank_mask,
   output logic                    pending,
   output logic                    frame_done,
   output logic [7:0]              seg_data,
   output logic [N_DIGITS-1:0]     seg_com
);

   localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0]    DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]    DIGIT_PRE  = CNT_W'(DIGIT_CYCLES - 2);
   localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [7:0]          SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;
   localparam logic [N_DIGITS-1:0] COM_OFF    = COM_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

   scan_state_t               state;
   logic [IDX_W-1:0]          idx;
   logic [CNT_W-1:0]          cnt;

   logic [4*N_DIGITS-1:0]     shadow_data;
   logic [N_DIGITS-1:0]       shadow_dp;
   logic [N_DIGITS-1:0]       shadow_blank;
   logic [4*N_DIGITS-1:0]     active_data;
   logic [N_DIGITS-1:0]       active_dp;
   logic [N_DIGITS-1:0]       active_blank;

   logic [3:0]                nibble;
   logic [6:0]                pattern;
   logic [7:0]                lit_seg;
   logic [N_DIGITS-1:0]       lit_com;

   assign nibble = active_data[4*int'(idx) +: 4];

   seg7_hex_decode u_decode (
      .nibble (nibble),
      .segs   (pattern)
   );

   always_comb begin
      lit_seg         = '0;
      lit_seg[6:0]    = pattern;
      lit_seg[SEG_DP] = active_dp[idx];
      if (active_blank[idx]) begin
         lit_seg = 8'h00;
      end
      if (SEG_ACT_LOW) begin
         lit_seg = ~lit_seg;
      end
   end

   always_comb begin
      lit_com      = '0;
      lit_com[idx] = 1'b1;
      if (COM_ACT_LOW) begin
         lit_com = ~lit_com;
      end
   end

   always_ff @(posedge clk_125mhz) begin
      if (reset) begin
         state        <= ST_BLANK;
         idx          <= '0;
         cnt          <= '0;
         shadow_data  <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '0;
         active_data  <= '0;
         active_dp    <= '0;
         active_blank <= '1;
         pending      <= 1'b0;
         frame_done   <= 1'b0;
         seg_data     <= SEG_OFF;
         seg_com      <= COM_OFF;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state    <= ST_ON;
                  cnt      <= '0;
                  seg_data <= lit_seg;
                  seg_com  <= lit_com;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_ON: begin
               if (cnt == DIGIT_LAST) begin
                  state    <= ST_BLANK;
                  cnt      <= '0;
                  idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                  seg_data <= SEG_OFF;
                  seg_com  <= COM_OFF;
               end else begin
                  cnt <= cnt + 1'b1;
                  // Registered pulse lands on the final lit cycle of the last digit
                  if (idx == IDX_LAST && cnt == DIGIT_PRE) begin
                     frame_done <= 1'b1;
                  end
               end
            end
            default: state <= ST_BLANK;
         endcase

         // frame_done marks the only cycle where the active buffer may change
         if (load) begin
            if (frame_done) begin
               active_data  <= load_data;
               active_dp    <= dp_mask;
               active_blank <= blank_mask;
               pending      <= 1'b0;
            end else begin
               shadow_data  <= load_data;
               shadow_dp    <= dp_mask;
               shadow_blank <= blank_mask;
               pending      <= 1'b1;
            end
         end else if (frame_done && pending) begin
            active_data  <= shadow_data;
            active_dp    <= shadow_dp;
            active_blank <= shadow_blank;
            pending      <= 1'b0;
         end
      end
   end

endmodule
